// File: rtl/ir_multi_event_catcher_if.sv
// Event stream from the multi-channel IR catcher to the decoder/CSR layer.
// The master side holds the FIFO head; the slave side pops it with ev_ready.
interface ir_multi_event_catcher_if #(
    parameter int NCH   = 4,
    parameter int DBITS = 16
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic             ev_valid;
    logic             ev_ready;
    logic [CW-1:0]    ev_channel;
    logic             ev_type;
    logic [DBITS-1:0] ev_delay;
    logic             ev_timeout;

    modport master (
        output ev_valid,
        output ev_channel,
        output ev_type,
        output ev_delay,
        output ev_timeout,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_channel,
        input  ev_type,
        input  ev_delay,
        input  ev_timeout,
        output ev_ready
    );
endinterface

// File: rtl/ir_multi_event_catcher.sv
// Multi-channel IR edge catcher: per-channel edge filter and delay counter,
// fixed-priority arbiter and registered first-word-fall-through event FIFO.
module ir_multi_event_catcher #(
    parameter int NCH    = 4,
    parameter int DBITS  = 16,
    parameter int FDEPTH = 8,
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int LW    = $clog2(FDEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_n,
    input  logic [DBITS-1:0]     reload_offset,
    input  logic [2*NCH-1:0]     edge_mode,
    input  logic [NCH-1:0]       i_value,
    input  logic                 i_valid,
    ir_multi_event_catcher_if.master ev,
    output logic [LW-1:0]        fifo_level,
    output logic                 overflow,
    output logic [7:0]           drop_cnt
);
    localparam int AW = $clog2(FDEPTH);
    localparam int EW = CW + 2 + DBITS;
    localparam logic [DBITS-1:0] ONES = '1;

    logic [NCH-1:0]   last_q;
    logic [NCH-1:0]   pend_q;
    logic [NCH-1:0]   ptype_q;
    logic [NCH-1:0]   pto_q;
    logic [DBITS-1:0] cnt_q  [NCH];
    logic [DBITS-1:0] pdly_q [NCH];

    logic [NCH-1:0] acc;
    logic [NCH-1:0] grant;
    logic [NCH-1:0] load;
    logic [NCH-1:0] drop;
    logic           push;
    logic           pop;
    logic           full;
    logic [EW-1:0]  push_data;
    logic [8:0]     ndrop;
    logic [8:0]     drop_sum;

    logic [EW-1:0]  mem [FDEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [EW-1:0]  head;

    assign full = (fifo_level == LW'(FDEPTH));
    assign pop  = ev.ev_valid & ev.ev_ready;

    always_comb begin
        acc = '0;
        for (int c = 0; c < NCH; c++) begin
            if (i_valid && (i_value[c] != last_q[c])) begin
                case (edge_mode[2*c +: 2])
                    2'b00:   acc[c] = 1'b1;
                    2'b01:   acc[c] = i_value[c];
                    2'b10:   acc[c] = ~i_value[c];
                    default: acc[c] = 1'b0;
                endcase
            end
        end
    end

    // Lowest index wins; at most one push per cycle.
    always_comb begin
        grant     = '0;
        push      = 1'b0;
        push_data = '0;
        for (int c = 0; c < NCH; c++) begin
            if (!full && pend_q[c] && !push) begin
                grant[c]  = 1'b1;
                push      = 1'b1;
                push_data = {CW'(c), ptype_q[c], pto_q[c], pdly_q[c]};
            end
        end
    end

    assign load = acc & (~pend_q | grant);
    assign drop = acc & pend_q & ~grant;

    always_comb begin
        ndrop = '0;
        for (int c = 0; c < NCH; c++) begin
            ndrop = ndrop + {8'd0, drop[c]};
        end
        drop_sum = {1'b0, drop_cnt} + ndrop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= '0;
            pend_q  <= '0;
            ptype_q <= '0;
            pto_q   <= '0;
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c]  <= ONES;
                pdly_q[c] <= '0;
            end
        end else if (!clear_n) begin
            last_q  <= '0;
            pend_q  <= '0;
            ptype_q <= '0;
            pto_q   <= '0;
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c]  <= ONES;
                pdly_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (i_valid) begin
                    last_q[c] <= i_value[c];
                    if (acc[c]) begin
                        cnt_q[c] <= reload_offset;
                    end else if (cnt_q[c] != ONES) begin
                        cnt_q[c] <= cnt_q[c] + 1'b1;
                    end
                end
                if (load[c]) begin
                    pend_q[c]  <= 1'b1;
                    ptype_q[c] <= i_value[c];
                    pto_q[c]   <= (cnt_q[c] == ONES);
                    pdly_q[c]  <= (cnt_q[c] == ONES) ? ONES
                                                     : cnt_q[c] + 1'b1;
                end else if (grant[c]) begin
                    pend_q[c] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (!clear_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (|drop) begin
            overflow <= 1'b1;
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    // Storage carries no reset; stale words are masked by ev_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (!clear_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    assign head          = mem[rd_ptr];
    assign ev.ev_valid   = (fifo_level != '0);
    assign ev.ev_channel = ev.ev_valid ? head[EW-1 -: CW] : '0;
    assign ev.ev_type    = ev.ev_valid & head[DBITS+1];
    assign ev.ev_timeout = ev.ev_valid & head[DBITS];
    assign ev.ev_delay   = ev.ev_valid ? head[DBITS-1:0] : '0;
endmodule

// File: tb/tb_ir_multi_event_catcher.sv
// Directed bench for ir_multi_event_catcher with an expected-event queue
// drained by a monitor on every FIFO pop.
module tb_ir_multi_event_catcher;
    localparam int NCH    = 4;
    localparam int DBITS  = 16;
    localparam int FDEPTH = 8;
    localparam int TO     = 65535;

    typedef struct {
        int ch;
        int typ;
        int dly;
        int to;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear_n;
    logic [DBITS-1:0] reload_offset;
    logic [2*NCH-1:0] edge_mode;
    logic [NCH-1:0]   i_value;
    logic             i_valid;
    logic [3:0]       fifo_level;
    logic             overflow;
    logic [7:0]       drop_cnt;

    int   n_chk  = 0;
    int   n_fail = 0;
    ev_t  exp_q[$];
    ev_t  mon_e;

    ir_multi_event_catcher_if #(.NCH(NCH), .DBITS(DBITS)) evif ();

    ir_multi_event_catcher #(
        .NCH(NCH),
        .DBITS(DBITS),
        .FDEPTH(FDEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clear_n(clear_n),
        .reload_offset(reload_offset),
        .edge_mode(edge_mode),
        .i_value(i_value),
        .i_valid(i_valid),
        .ev(evif),
        .fifo_level(fifo_level),
        .overflow(overflow),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [NCH-1:0] v);
        i_value = v;
        i_valid = 1'b1;
        step();
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        step(n);
    endtask

    task automatic expect_ev(input int ch, input int typ, input int dly,
                             input int to);
        exp_q.push_back('{ch, typ, dly, to});
    endtask

    task automatic do_clear();
        i_valid = 1'b0;
        clear_n = 1'b0;
        step();
        clear_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && clear_n && evif.ev_valid && evif.ev_ready) begin
            chk("ev_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("ev_channel", 32'(evif.ev_channel), mon_e.ch);
                chk("ev_type", 32'(evif.ev_type), mon_e.typ);
                chk("ev_delay", 32'(evif.ev_delay), mon_e.dly);
                chk("ev_timeout", 32'(evif.ev_timeout), mon_e.to);
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        clear_n       = 1'b1;
        reload_offset = '0;
        edge_mode     = '0;
        i_value       = '0;
        i_valid       = 1'b0;
        evif.ev_ready = 1'b0;
        step(2);
        rst_n = 1'b1;
        step();

        chk("rst_valid", 32'(evif.ev_valid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_channel", 32'(evif.ev_channel), 0);
        chk("rst_delay", 32'(evif.ev_delay), 0);

        // single channel, both edges, latency
        evif.ev_ready = 1'b1;
        repeat (5) strobe(4'b0000);
        strobe(4'b0001);
        expect_ev(0, 1, TO, 1);
        chk("lat_t1", 32'(evif.ev_valid), 0);
        strobe(4'b0001);
        chk("lat_t2", 32'(evif.ev_valid), 1);
        strobe(4'b0001);
        strobe(4'b0000);
        expect_ev(0, 0, 3, 0);
        idle(4);
        chk("single_drained", 32'(exp_q.size()), 0);

        // rising-only filter on ch1, then disabled
        edge_mode = 8'b0000_0100;
        for (int p = 0; p < 4; p++) begin
            strobe(4'b0010);
            expect_ev(1, 1, (p == 0) ? TO : 4, (p == 0) ? 1 : 0);
            strobe(4'b0010);
            strobe(4'b0000);
            strobe(4'b0000);
        end
        edge_mode = 8'b0000_1100;
        for (int p = 0; p < 2; p++) begin
            strobe(4'b0010);
            strobe(4'b0010);
            strobe(4'b0000);
            strobe(4'b0000);
        end
        chk("disabled_level", 32'(fifo_level), 0);
        chk("disabled_valid", 32'(evif.ev_valid), 0);
        edge_mode = 8'b0000_0000;
        strobe(4'b0000);
        strobe(4'b0010);
        expect_ev(1, 1, 13, 0);
        idle(4);
        chk("filter_drained", 32'(exp_q.size()), 0);

        // simultaneous edges on ch0, ch2, ch3
        do_clear();
        evif.ev_ready = 1'b0;
        strobe(4'b1101);
        expect_ev(0, 1, TO, 1);
        expect_ev(2, 1, TO, 1);
        expect_ev(3, 1, TO, 1);
        chk("simul_lvl0", 32'(fifo_level), 0);
        idle(1);
        chk("simul_lvl1", 32'(fifo_level), 1);
        idle(1);
        chk("simul_lvl2", 32'(fifo_level), 2);
        idle(1);
        chk("simul_lvl3", 32'(fifo_level), 3);
        idle(1);
        chk("simul_hold", 32'(fifo_level), 3);
        chk("simul_head", 32'(evif.ev_channel), 0);
        evif.ev_ready = 1'b1;
        idle(5);
        chk("simul_drained", 32'(exp_q.size()), 0);

        // backpressure: 12 edges, 8 queued, 1 pending, 3 dropped
        do_clear();
        evif.ev_ready = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            strobe(4'(k % 2));
            if (k <= 9) begin
                expect_ev(0, k % 2, (k == 1) ? TO : 3, (k == 1) ? 1 : 0);
            end
            if (k == 9) begin
                chk("bp_ovf_before", 32'(overflow), 0);
            end
            if (k == 10) begin
                chk("bp_ovf_after", 32'(overflow), 1);
            end
            strobe(4'(k % 2));
            strobe(4'(k % 2));
        end
        idle(2);
        chk("bp_full", 32'(fifo_level), FDEPTH);
        chk("bp_drop", 32'(drop_cnt), 3);
        chk("bp_head_type", 32'(evif.ev_type), 1);
        chk("bp_head_delay", 32'(evif.ev_delay), TO);
        idle(3);
        chk("bp_stable_delay", 32'(evif.ev_delay), TO);
        chk("bp_stable_to", 32'(evif.ev_timeout), 1);
        evif.ev_ready = 1'b1;
        idle(14);
        chk("bp_drained", 32'(exp_q.size()), 0);
        chk("bp_level0", 32'(fifo_level), 0);
        chk("bp_sticky", 32'(overflow), 1);

        // synchronous clear with events queued
        evif.ev_ready = 1'b0;
        strobe(4'b0001);
        strobe(4'b0001);
        strobe(4'b0000);
        strobe(4'b0000);
        strobe(4'b0001);
        strobe(4'b0001);
        strobe(4'b0000);
        strobe(4'b0000);
        idle(3);
        chk("clr_pre_level", 32'(fifo_level), 4);
        do_clear();
        chk("clr_valid", 32'(evif.ev_valid), 0);
        chk("clr_level", 32'(fifo_level), 0);
        chk("clr_overflow", 32'(overflow), 0);
        chk("clr_drop", 32'(drop_cnt), 0);
        idle(3);
        chk("clr_no_pend", 32'(fifo_level), 0);
        evif.ev_ready = 1'b1;
        strobe(4'b0001);
        expect_ev(0, 1, TO, 1);
        idle(4);
        chk("clr_drained", 32'(exp_q.size()), 0);

        // asynchronous reset with events queued
        evif.ev_ready = 1'b0;
        strobe(4'b0000);
        strobe(4'b0000);
        strobe(4'b0001);
        strobe(4'b0001);
        strobe(4'b0000);
        strobe(4'b0000);
        strobe(4'b0001);
        strobe(4'b0001);
        idle(3);
        chk("rst_pre_level", 32'(fifo_level), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(evif.ev_valid), 0);
        chk("arst_level", 32'(fifo_level), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_hold", 32'(fifo_level), 0);

        // reload offset 5: first event times out, next reports 8
        reload_offset = 16'd5;
        evif.ev_ready = 1'b1;
        strobe(4'b0001);
        expect_ev(0, 1, TO, 1);
        strobe(4'b0001);
        strobe(4'b0001);
        strobe(4'b0000);
        expect_ev(0, 0, 8, 0);
        idle(4);
        chk("reload_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
